// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: phase sequencer for a four-way intersection.
// Drives car and pedestrian lamps for the N/S and E/W axes from one FSM, with
// programmable phase durations and emergency-vehicle preemption.
// Ports:
//   clk, rst            - clock (rising edge), asynchronous active-high reset
//   i_start             - leaves IDLE when sampled high
//   i_emg, i_emg_ew     - preemption request (level) and its axis (0 N/S, 1 E/W)
//   o_ns_car, o_ew_car  - car lamps: 00 RED, 01 GREEN, 10 YELLOW, 11 LEFT
//   o_ns_ped, o_ew_ped  - pedestrian lamps: 00 RED, 01 GREEN, 10 BLINK
//   o_cycle             - schedule position, 0 in IDLE
//   o_state, o_preempt  - current state code, high in any PRE_* state
module traffic_phase_ctrl #(
    parameter int T_GO    = 14,
    parameter int T_BLINK = 6,
    parameter int T_YEL   = 2,
    parameter int T_LEFT  = 10,
    parameter int T_AR    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic       i_emg,
    input  logic       i_emg_ew,
    output logic [1:0] o_ns_car,
    output logic [1:0] o_ns_ped,
    output logic [1:0] o_ew_car,
    output logic [1:0] o_ew_ped,
    output logic [6:0] o_cycle,
    output logic [3:0] o_state,
    output logic       o_preempt
);
    localparam int HalfLen = T_GO + T_BLINK + 2 * T_YEL + T_LEFT;
    localparam logic [6:0] CycMax  = 7'(2 * HalfLen);
    localparam logic [6:0] EwStart = 7'(HalfLen + 1);
    // Down-counter load values: a phase of N cycles counts N-1 .. 0.
    localparam logic [6:0] LdGo    = 7'(T_GO - 1);
    localparam logic [6:0] LdBlink = 7'(T_BLINK - 1);
    localparam logic [6:0] LdYel   = 7'(T_YEL - 1);
    localparam logic [6:0] LdLeft  = 7'(T_LEFT - 1);
    localparam logic [6:0] LdAr    = 7'(T_AR - 1);

    if (T_GO < 1 || T_BLINK < 1 || T_YEL < 1 || T_LEFT < 1 || T_AR < 1 || HalfLen > 63)
    begin : g_param_check
        $error("traffic_phase_ctrl: illegal phase durations");
    end

    localparam logic [1:0] Red    = 2'b00;
    localparam logic [1:0] Green  = 2'b01;
    localparam logic [1:0] Yellow = 2'b10;  // also pedestrian BLINK
    localparam logic [1:0] Left   = 2'b11;

    typedef enum logic [3:0] {
        StIdle     = 4'd0,
        StNsGo     = 4'd1,
        StNsWend   = 4'd2,
        StNsY1     = 4'd3,
        StNsLeft   = 4'd4,
        StNsY2     = 4'd5,
        StEwGo     = 4'd6,
        StEwWend   = 4'd7,
        StEwY1     = 4'd8,
        StEwLeft   = 4'd9,
        StEwY2     = 4'd10,
        StPreY     = 4'd11,
        StPreAr    = 4'd12,
        StPreGrant = 4'd13,
        StPreExit  = 4'd14
    } state_e;

    function automatic logic [6:0] phase_load(state_e s);
        case (s)
            StNsGo, StEwGo:     phase_load = LdGo;
            StNsWend, StEwWend: phase_load = LdBlink;
            StNsLeft, StEwLeft: phase_load = LdLeft;
            default:            phase_load = LdYel;
        endcase
    endfunction

    function automatic state_e next_phase(state_e s);
        case (s)
            StNsGo:   next_phase = StNsWend;
            StNsWend: next_phase = StNsY1;
            StNsY1:   next_phase = StNsLeft;
            StNsLeft: next_phase = StNsY2;
            StNsY2:   next_phase = StEwGo;
            StEwGo:   next_phase = StEwWend;
            StEwWend: next_phase = StEwY1;
            StEwY1:   next_phase = StEwLeft;
            StEwLeft: next_phase = StEwY2;
            StEwY2:   next_phase = StNsGo;
            default:  next_phase = StIdle;
        endcase
    endfunction

    // Lamp decode {ns_car, ns_ped, ew_car, ew_ped}; ax is the interrupted axis,
    // dir the latched emergency axis.
    function automatic logic [7:0] lamps(state_e s, logic ax, logic dir);
        logic [1:0] ns_car, ns_ped, ew_car, ew_ped;
        ns_car = Red;
        ns_ped = Red;
        ew_car = Red;
        ew_ped = Red;
        case (s)
            StNsGo:   begin ns_car = Green; ew_ped = Green;  end
            StNsWend: begin ns_car = Green; ew_ped = Yellow; end
            StNsY1, StNsY2: ns_car = Yellow;
            StNsLeft: ns_car = Left;
            StEwGo:   begin ew_car = Green; ns_ped = Green;  end
            StEwWend: begin ew_car = Green; ns_ped = Yellow; end
            StEwY1, StEwY2: ew_car = Yellow;
            StEwLeft: ew_car = Left;
            StPreY:     if (ax)  ew_car = Yellow; else ns_car = Yellow;
            StPreGrant: if (dir) ew_car = Green;  else ns_car = Green;
            StPreExit:  if (dir) ew_car = Yellow; else ns_car = Yellow;
            default: ;
        endcase
        lamps = {ns_car, ns_ped, ew_car, ew_ped};
    endfunction

    state_e     state_q, state_d, resume_state;
    logic [6:0] cnt_q, cnt_d, cycle_q, cycle_d, cycle_inc, resume_cycle;
    logic       dir_q, dir_d, ax_q, ax_d, pend_q, pend_d, pre_q;
    logic [7:0] lamps_q;
    logic       is_yel, is_ew;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cycle_d      = cycle_q;
        dir_d        = dir_q;
        ax_d         = ax_q;
        pend_d       = pend_q;
        cycle_inc    = (cycle_q >= CycMax) ? 7'd1 : cycle_q + 7'd1;
        resume_state = dir_q ? StNsGo : StEwGo;
        resume_cycle = dir_q ? 7'd1 : EwStart;
        is_yel       = state_q inside {StNsY1, StNsY2, StEwY1, StEwY2};
        is_ew        = state_q inside {StEwGo, StEwWend, StEwY1, StEwLeft, StEwY2};
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    state_d = StNsGo;
                    cnt_d   = LdGo;
                    cycle_d = 7'd1;
                    pend_d  = 1'b0;
                end
            end
            StPreY: begin
                if (cnt_q == 7'd0) begin
                    state_d = StPreAr;
                    cnt_d   = LdAr;
                end else begin
                    cnt_d = cnt_q - 7'd1;
                end
            end
            StPreAr, StPreExit: begin
                if (cnt_q != 7'd0) begin
                    cnt_d = cnt_q - 7'd1;
                end else if (state_q == StPreAr && i_emg) begin
                    state_d = StPreGrant;
                end else begin
                    state_d = resume_state;
                    cnt_d   = LdGo;
                    cycle_d = resume_cycle;
                end
            end
            StPreGrant: begin
                if (!i_emg) begin
                    state_d = StPreExit;
                    cnt_d   = LdYel;
                end
            end
            StNsGo, StNsWend, StNsY1, StNsLeft, StNsY2,
            StEwGo, StEwWend, StEwY1, StEwLeft, StEwY2: begin
                if (is_yel) begin
                    // A request during yellow lets the yellow run out, then skips PRE_Y.
                    if (i_emg && !pend_q) begin
                        pend_d = 1'b1;
                        dir_d  = i_emg_ew;
                        ax_d   = is_ew;
                    end
                    if (cnt_q == 7'd0 && (pend_q || i_emg)) begin
                        state_d = StPreAr;
                        cnt_d   = LdAr;
                        pend_d  = 1'b0;
                    end else if (cnt_q == 7'd0) begin
                        state_d = next_phase(state_q);
                        cnt_d   = phase_load(next_phase(state_q));
                        cycle_d = cycle_inc;
                    end else begin
                        cnt_d   = cnt_q - 7'd1;
                        cycle_d = cycle_inc;
                    end
                end else if (i_emg) begin
                    state_d = StPreY;
                    cnt_d   = LdYel;
                    dir_d   = i_emg_ew;
                    ax_d    = is_ew;
                end else if (cnt_q == 7'd0) begin
                    state_d = next_phase(state_q);
                    cnt_d   = phase_load(next_phase(state_q));
                    cycle_d = cycle_inc;
                end else begin
                    cnt_d   = cnt_q - 7'd1;
                    cycle_d = cycle_inc;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 7'd0;
                cycle_d = 7'd0;
            end
        endcase
    end

    // Lamps and o_preempt are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 7'd0;
            cycle_q <= 7'd0;
            dir_q   <= 1'b0;
            ax_q    <= 1'b0;
            pend_q  <= 1'b0;
            lamps_q <= 8'd0;
            pre_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cycle_q <= cycle_d;
            dir_q   <= dir_d;
            ax_q    <= ax_d;
            pend_q  <= pend_d;
            lamps_q <= lamps(state_d, ax_d, dir_d);
            pre_q   <= state_d inside {StPreY, StPreAr, StPreGrant, StPreExit};
        end
    end

    assign {o_ns_car, o_ns_ped, o_ew_car, o_ew_ped} = lamps_q;
    assign o_cycle   = cycle_q;
    assign o_state   = state_q;
    assign o_preempt = pre_q;
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb_traffic_phase_ctrl: directed-vector bench for traffic_phase_ctrl at default durations.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_traffic_phase_ctrl;
    logic       clk = 1'b0;
    logic       rst, i_start, i_emg, i_emg_ew;
    logic [1:0] o_ns_car, o_ns_ped, o_ew_car, o_ew_ped;
    logic [6:0] o_cycle;
    logic [3:0] o_state;
    logic       o_preempt;

    int n_vec = 0;
    int n_err = 0;
    int cyc_m;  // expected schedule position

    traffic_phase_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .i_start   (i_start),
        .i_emg     (i_emg),
        .i_emg_ew  (i_emg_ew),
        .o_ns_car  (o_ns_car),
        .o_ns_ped  (o_ns_ped),
        .o_ew_car  (o_ew_car),
        .o_ew_ped  (o_ew_ped),
        .o_cycle   (o_cycle),
        .o_state   (o_state),
        .o_preempt (o_preempt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic int next_cyc(int c);
        return (c == 68) ? 1 : c + 1;
    endfunction

    // Normal schedule: NS 1-14 GO, 15-20 WEND, 21-22 Y1, 23-32 LEFT, 33-34 Y2; EW +34.
    function automatic int exp_state(int c);
        int h, base;
        h    = (c > 34) ? c - 34 : c;
        base = (c > 34) ? 5 : 0;
        if (h <= 14) return base + 1;
        if (h <= 20) return base + 2;
        if (h <= 22) return base + 3;
        if (h <= 32) return base + 4;
        return base + 5;
    endfunction

    task automatic check_lamps(input string tag, input int nsc, input int nsp, input int ewc,
                               input int ewp);
        check_eq({tag, " ns_car"}, int'(o_ns_car), nsc);
        check_eq({tag, " ns_ped"}, int'(o_ns_ped), nsp);
        check_eq({tag, " ew_car"}, int'(o_ew_car), ewc);
        check_eq({tag, " ew_ped"}, int'(o_ew_ped), ewp);
    endtask

    task automatic goto_cycle(input int target);
        while (cyc_m != target) begin
            tick();
            cyc_m = next_cyc(cyc_m);
        end
        check_eq($sformatf("goto %0d cycle", target), int'(o_cycle), target);
        check_eq($sformatf("goto %0d state", target), int'(o_state), exp_state(target));
    endtask

    // One clock with i_emg = e, then full output check.
    task automatic pre_step(input string tag, input logic e, input int st, input int cyc,
                            input int nsc, input int nsp, input int ewc, input int ewp);
        i_emg = e;
        tick();
        check_eq({tag, " state"}, int'(o_state), st);
        check_eq({tag, " cycle"}, int'(o_cycle), cyc);
        check_eq({tag, " preempt"}, int'(o_preempt), (st >= 11 && st <= 14) ? 1 : 0);
        check_lamps(tag, nsc, nsp, ewc, ewp);
    endtask

    initial begin
        rst = 1'b1; i_start = 1'b0; i_emg = 1'b0; i_emg_ew = 1'b0;
        #1;
        check_eq("rst state", int'(o_state), 0);
        check_eq("rst cycle", int'(o_cycle), 0);
        check_eq("rst preempt", int'(o_preempt), 0);
        check_lamps("rst", 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_eq("idle hold state", int'(o_state), 0);

        // Start and walk the first schedule points
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check_eq("start cycle", int'(o_cycle), 1);
        check_eq("start state", int'(o_state), 1);
        check_lamps("c1", 1, 0, 0, 1);
        repeat (14) tick();
        check_eq("c15 cycle", int'(o_cycle), 15);
        check_eq("c15 state", int'(o_state), 2);
        check_lamps("c15", 1, 0, 0, 2);
        repeat (6) tick();
        check_eq("c21 state", int'(o_state), 3);
        check_lamps("c21", 2, 0, 0, 0);
        repeat (2) tick();
        check_eq("c23 state", int'(o_state), 4);
        check_lamps("c23", 3, 0, 0, 0);
        repeat (12) tick();
        check_eq("c35 cycle", int'(o_cycle), 35);
        check_eq("c35 state", int'(o_state), 6);
        check_lamps("c35", 0, 1, 1, 0);
        repeat (22) tick();
        check_eq("c57 cycle", int'(o_cycle), 57);
        check_eq("c57 state", int'(o_state), 9);
        check_lamps("c57", 0, 0, 3, 0);
        cyc_m = 57;

        // 140 cycles across wraps; i_start pulses outside IDLE must be ignored
        for (int i = 0; i < 140; i++) begin
            i_start = (i < 10);
            tick();
            cyc_m = next_cyc(cyc_m);
            check_eq($sformatf("run c=%0d cycle", cyc_m), int'(o_cycle), cyc_m);
            check_eq($sformatf("run c=%0d state", cyc_m), int'(o_state), exp_state(cyc_m));
        end
        i_start = 1'b0;

        // Preempt toward E/W from NS_GO, held 10 cycles
        goto_cycle(5);
        i_emg_ew = 1'b1;
        pre_step("p3 y0", 1'b1, 11, 5, 2, 0, 0, 0);
        pre_step("p3 y1", 1'b1, 11, 5, 2, 0, 0, 0);
        pre_step("p3 ar0", 1'b1, 12, 5, 0, 0, 0, 0);
        pre_step("p3 ar1", 1'b1, 12, 5, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) pre_step($sformatf("p3 g%0d", i), 1'b1, 13, 5, 0, 0, 1, 0);
        pre_step("p3 x0", 1'b0, 14, 5, 0, 0, 2, 0);
        pre_step("p3 x1", 1'b0, 14, 5, 0, 0, 2, 0);
        pre_step("p3 resume", 1'b0, 1, 1, 1, 0, 0, 1);
        cyc_m = 1;

        // Preempt toward N/S during NS_Y1: yellow completes, no PRE_Y
        goto_cycle(21);
        i_emg_ew = 1'b0;
        pre_step("p4 y", 1'b1, 3, 22, 2, 0, 0, 0);
        pre_step("p4 ar0", 1'b1, 12, 22, 0, 0, 0, 0);
        pre_step("p4 ar1", 1'b1, 12, 22, 0, 0, 0, 0);
        pre_step("p4 g0", 1'b1, 13, 22, 1, 0, 0, 0);
        pre_step("p4 g1", 1'b1, 13, 22, 1, 0, 0, 0);
        pre_step("p4 x0", 1'b0, 14, 22, 2, 0, 0, 0);
        pre_step("p4 x1", 1'b0, 14, 22, 2, 0, 0, 0);
        pre_step("p4 resume", 1'b0, 6, 35, 0, 1, 1, 0);
        cyc_m = 35;

        // One-cycle pulse toward E/W in EW_GO: no grant
        goto_cycle(40);
        i_emg_ew = 1'b1;
        pre_step("p5 y0", 1'b1, 11, 40, 0, 0, 2, 0);
        pre_step("p5 y1", 1'b0, 11, 40, 0, 0, 2, 0);
        pre_step("p5 ar0", 1'b0, 12, 40, 0, 0, 0, 0);
        pre_step("p5 ar1", 1'b0, 12, 40, 0, 0, 0, 0);
        pre_step("p5 resume", 1'b0, 1, 1, 1, 0, 0, 1);

        // Asynchronous reset during PRE_GRANT
        i_emg_ew = 1'b0;
        pre_step("p6 y0", 1'b1, 11, 1, 2, 0, 0, 0);
        pre_step("p6 y1", 1'b1, 11, 1, 2, 0, 0, 0);
        pre_step("p6 ar0", 1'b1, 12, 1, 0, 0, 0, 0);
        pre_step("p6 ar1", 1'b1, 12, 1, 0, 0, 0, 0);
        pre_step("p6 g", 1'b1, 13, 1, 1, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        check_eq("arst state", int'(o_state), 0);
        check_eq("arst cycle", int'(o_cycle), 0);
        check_eq("arst preempt", int'(o_preempt), 0);
        check_lamps("arst", 0, 0, 0, 0);
        i_emg = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) tick();
        check_eq("post-rst idle state", int'(o_state), 0);
        check_eq("post-rst idle cycle", int'(o_cycle), 0);

        // Start and emergency together in IDLE: start wins, emergency taken next edge
        i_start = 1'b1; i_emg = 1'b1; i_emg_ew = 1'b1;
        tick();
        i_start = 1'b0;
        check_eq("both state", int'(o_state), 1);
        check_eq("both cycle", int'(o_cycle), 1);
        tick();
        check_eq("both pre state", int'(o_state), 11);
        check_eq("both pre cycle", int'(o_cycle), 1);
        check_eq("both pre preempt", int'(o_preempt), 1);
        check_lamps("both pre", 2, 0, 0, 0);
        i_emg = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/traffic_phase_ctrl.md
Name: traffic_phase_ctrl

Overview:
- Central phase sequencer for a four-way intersection. It generates the car and pedestrian signals for the N/S and E/W axes from a single state machine.
- It replaces the free-running 68-cycle counter with programmable phase durations and adds emergency-vehicle preemption.
- Signal encodings match the existing light drivers, so the outputs feed the per-direction lamp logic directly.

Parameters:
- T_GO, 14, cycles of an axis's car GREEN with the cross pedestrians on GREEN.
- T_BLINK, 6, cycles of car GREEN with the cross pedestrians on BLINK.
- T_YEL, 2, cycles of each YELLOW phase (normal, preempt-entry, preempt-exit).
- T_LEFT, 10, cycles of the protected LEFT phase.
- T_AR, 2, cycles of preempt all-red.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_start  in  1  leaves IDLE when sampled high.
- i_emg  in  1  emergency preemption request, level.
- i_emg_ew  in  1  emergency direction: 0 = N/S, 1 = E/W.
- o_ns_car  out  2  N/S car signal: 00 RED, 01 GREEN, 10 YELLOW, 11 LEFT.
- o_ns_ped  out  2  N/S pedestrian signal: 00 RED, 01 GREEN, 10 BLINK.
- o_ew_car  out  2  E/W car signal, same encoding as o_ns_car.
- o_ew_ped  out  2  E/W pedestrian signal, same encoding as o_ns_ped.
- o_cycle  out  7  schedule position 1..2*(T_GO+T_BLINK+2*T_YEL+T_LEFT); 0 in IDLE.
- o_state  out  4  current state code.
- o_preempt  out  1  high in any PRE_* state.

Behaviour:
- Reset: async on rst high. State=IDLE, o_cycle=0, phase down-counter cleared, all outputs 00, o_preempt=0.
- Mid-operation reset has the same effect, and the block waits for i_start again.
- Outputs are Moore, decoded from the state only. Any pair not listed below is RED (00).

State codes and outputs:
- 0 IDLE.
- 1 NS_GO: ns_car GREEN, ew_ped GREEN.
- 2 NS_WEND: ns_car GREEN, ew_ped BLINK.
- 3 NS_Y1: ns_car YELLOW.
- 4 NS_LEFT: ns_car LEFT.
- 5 NS_Y2: ns_car YELLOW.
- 6..10 EW_GO, EW_WEND, EW_Y1, EW_LEFT, EW_Y2: mirror of states 1..5 with the axes swapped.
- 11 PRE_Y: interrupted axis car YELLOW.
- 12 PRE_AR: all RED.
- 13 PRE_GRANT: latched emergency axis car GREEN, all pedestrians RED.
- 14 PRE_EXIT: latched axis car YELLOW.

Normal sequencing:
- i_start high at an edge in IDLE: the next state is NS_GO and o_cycle=1.
- Each phase lasts its parameter duration, counted with a down-counter.
- Order: NS_GO, NS_WEND, NS_Y1, NS_LEFT, NS_Y2, then EW_GO ... EW_Y2, then back to NS_GO.
- o_cycle increments every cycle and wraps from its maximum (68 at defaults) to 1.
- i_start outside IDLE is ignored.

Preemption entry:
- i_emg is sampled only in states 1..10. At entry, latch dir = i_emg_ew and freeze o_cycle.
- From GO, WEND or LEFT: the next state is PRE_Y for T_YEL cycles.
- From a yellow state: finish the remaining count, then go to PRE_AR, skipping PRE_Y.
- PRE_AR lasts T_AR cycles.
- At the end of PRE_AR: if i_emg is high, go to PRE_GRANT; otherwise resume without a grant (see resume rule).

Grant and exit:
- PRE_GRANT is held while i_emg is high, minimum 1 cycle.
- i_emg low at an edge in PRE_GRANT: go to PRE_EXIT for T_YEL cycles, then resume.

Resume rule:
- Enter the GO state of the axis opposite dir, with the full T_GO duration.
- o_cycle is loaded with that phase's start: 1 for NS_GO, T_GO+T_BLINK+2*T_YEL+T_LEFT+1 (35 at defaults) for EW_GO.

Boundary rules:
- i_emg re-assertion or a dir change inside PRE_* is ignored. The new request is evaluated from the resumed GO onward.
- i_start and i_emg high together in IDLE: start wins, and i_emg is evaluated in NS_GO at the next edge.
- Counters are 7 bits. Require every T_* >= 1 and T_GO+T_BLINK+2*T_YEL+T_LEFT <= 63; otherwise simulation stops with $error at elaboration.

Test Plan:
1. Reset, then i_start=1 with defaults. Required: o_cycle=1 in NS_GO; at o_cycle 1 ns_car=01, ew_ped=01; at 15 ew_ped=10; at 21 ns_car=10; at 23 ns_car=11; at 35 ew_car=01, ns_ped=01; at 57 ew_car=11.
2. Run 140 cycles. Required: o_cycle goes 68 -> 1, o_state returns to 1, and there are no glitch states.
3. i_emg=1, i_emg_ew=1 at o_cycle 5, held 10 cycles. Required: 2 cycles ns_car=10, 2 all-red, ew_car=01 with all peds 00; 2 cycles ew_car=10 after the drop; then NS_GO with o_cycle=1. o_cycle is held at 5 throughout and o_preempt=1 for the whole preemption.
4. i_emg=1 (dir NS) at o_cycle 21 (NS_Y1, 2 remaining). Required: yellow completes at o_cycle 22, then PRE_AR (no PRE_Y), then PRE_GRANT with ns_car=01; on release, resume EW_GO with o_cycle=35.
5. 1-cycle i_emg pulse (dir EW) at o_cycle 40 (EW_GO). Required: PRE_Y 2, PRE_AR 2, no grant, then NS_GO with o_cycle=1.
6. rst pulse asynchronously during PRE_GRANT. Required: outputs 00, o_cycle=0, o_state=0 immediately, with no clock; the block stays IDLE until i_start.
